// File: rtl/stack_ctrl.sv
// Stack sequencer for the 13-entry stack register file. Accepts one command per
// cycle over valid/ready, owns the stack counter, and issues the register-file
// write for each command. SWAP takes two cycles: it first collapses the top two
// entries into one, then pushes the saved second entry back on top.
module stack_ctrl #(
  parameter int unsigned DEPTH = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_cmd,
  input  logic [7:0] req_imm,
  input  logic       clr_err,
  output logic       rf_we,
  output logic [1:0] rf_op,
  output logic [7:0] rf_di,
  output logic [3:0] rf_sc,
  input  logic [7:0] rf_do_a,
  input  logic [7:0] rf_do_b,
  output logic [7:0] top,
  output logic       top_valid,
  output logic       resp_valid,
  output logic       resp_err,
  output logic       err_ovf,
  output logic       err_unf
);

  localparam logic [2:0] CmdNop  = 3'b000;
  localparam logic [2:0] CmdPush = 3'b001;
  localparam logic [2:0] CmdPop  = 3'b010;
  localparam logic [2:0] CmdDup  = 3'b011;
  localparam logic [2:0] CmdAdd  = 3'b100;
  localparam logic [2:0] CmdSub  = 3'b101;
  localparam logic [2:0] CmdAnd  = 3'b110;
  localparam logic [2:0] CmdSwap = 3'b111;

  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpAdv  = 2'b01;  // writes core[sc]
  localparam logic [1:0] OpDes  = 2'b10;  // writes core[sc-2]

  localparam logic [3:0] DepthW = 4'(DEPTH);

  typedef enum logic [0:0] {StIdle, StSwap2} state_e;

  state_e      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [7:0]  swap_b_q, swap_b_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_unf_q, err_unf_d;

  logic        we_c;
  logic [1:0]  op_c;
  logic        ovf_set, unf_set;
  logic        has1, has2, full;

  assign has1 = (sc_q != 4'd0);
  assign has2 = (sc_q >= 4'd2);
  assign full = (sc_q >= DepthW);

  assign req_ready = (state_q == StIdle) && !reset;

  // Decode the current command (or the SWAP2 step) into the write and next state.
  always_comb begin
    we_c         = 1'b0;
    op_c         = OpNone;
    rf_di        = 8'h00;
    sc_d         = sc_q;
    state_d      = state_q;
    swap_b_d     = swap_b_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;

    if (state_q == StSwap2) begin
      we_c         = 1'b1;
      op_c         = OpAdv;
      rf_di        = swap_b_q;
      sc_d         = sc_q + 4'd1;
      state_d      = StIdle;
      resp_valid_d = 1'b1;
    end else if (req_valid && req_ready) begin
      resp_valid_d = 1'b1;
      unique case (req_cmd)
        CmdNop: ;
        CmdPush: begin
          if (!full) begin
            we_c  = 1'b1;
            op_c  = OpAdv;
            rf_di = req_imm;
            sc_d  = sc_q + 4'd1;
          end else begin
            ovf_set = 1'b1;
          end
        end
        CmdPop: begin
          if (has1) sc_d = sc_q - 4'd1;
          else      unf_set = 1'b1;
        end
        CmdDup: begin
          if (full) begin
            ovf_set = 1'b1;
          end else if (!has1) begin
            unf_set = 1'b1;
          end else begin
            we_c  = 1'b1;
            op_c  = OpAdv;
            rf_di = rf_do_a;
            sc_d  = sc_q + 4'd1;
          end
        end
        CmdAdd, CmdSub, CmdAnd: begin
          if (has2) begin
            we_c  = 1'b1;
            op_c  = OpDes;
            sc_d  = sc_q - 4'd1;
            if (req_cmd == CmdAdd)      rf_di = rf_do_b + rf_do_a;
            else if (req_cmd == CmdSub) rf_di = rf_do_b - rf_do_a;
            else                        rf_di = rf_do_b & rf_do_a;
          end else begin
            unf_set = 1'b1;
          end
        end
        CmdSwap: begin
          if (has2) begin
            // Overwrite next with top, then push the old next back in SWAP2.
            we_c         = 1'b1;
            op_c         = OpDes;
            rf_di        = rf_do_a;
            sc_d         = sc_q - 4'd1;
            swap_b_d     = rf_do_b;
            state_d      = StSwap2;
            resp_valid_d = 1'b0;
          end else begin
            unf_set = 1'b1;
          end
        end
        default: ;
      endcase
      resp_err_d = ovf_set | unf_set;
    end

    // A new error wins over a same-edge clear.
    err_ovf_d = ovf_set | (err_ovf_q & ~clr_err);
    err_unf_d = unf_set | (err_unf_q & ~clr_err);
  end

  // Reset kills any pending write at once, including an in-flight SWAP2.
  assign rf_we = we_c & ~reset;
  assign rf_op = reset ? OpNone : op_c;

  assign rf_sc      = sc_q;
  assign top        = rf_do_a;
  assign top_valid  = has1;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign err_ovf    = err_ovf_q;
  assign err_unf    = err_unf_q;

  // State, counter, saved SWAP operand, response and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      sc_q         <= 4'd0;
      swap_b_q     <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sc_q         <= sc_d;
      swap_b_q     <= swap_b_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      err_ovf_q    <= err_ovf_d;
      err_unf_q    <= err_unf_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a small register-file model closes the loop, and a
// queue-based stack model predicts the visible stack, responses and flags.
module tb_stack_ctrl;

  localparam logic [2:0] CmdNop  = 3'b000;
  localparam logic [2:0] CmdPush = 3'b001;
  localparam logic [2:0] CmdPop  = 3'b010;
  localparam logic [2:0] CmdDup  = 3'b011;
  localparam logic [2:0] CmdAdd  = 3'b100;
  localparam logic [2:0] CmdSub  = 3'b101;
  localparam logic [2:0] CmdAnd  = 3'b110;
  localparam logic [2:0] CmdSwap = 3'b111;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_cmd;
  logic [7:0] req_imm;
  logic       clr_err;
  logic       rf_we;
  logic [1:0] rf_op;
  logic [7:0] rf_di;
  logic [3:0] rf_sc;
  logic [7:0] rf_do_a;
  logic [7:0] rf_do_b;
  logic [7:0] top;
  logic       top_valid;
  logic       resp_valid;
  logic       resp_err;
  logic       err_ovf;
  logic       err_unf;

  int errors = 0;
  int checks = 0;

  stack_ctrl #(.DEPTH(13)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_imm   (req_imm),
    .clr_err   (clr_err),
    .rf_we     (rf_we),
    .rf_op     (rf_op),
    .rf_di     (rf_di),
    .rf_sc     (rf_sc),
    .rf_do_a   (rf_do_a),
    .rf_do_b   (rf_do_b),
    .top       (top),
    .top_valid (top_valid),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 clk = ~clk;

  // Register file the controller drives.
  logic [7:0] core [0:15];
  always @(posedge clk) begin
    if (rf_we) begin
      if (rf_op == 2'b01)      core[rf_sc] <= rf_di;
      else if (rf_op == 2'b10) core[rf_sc - 4'd2] <= rf_di;
    end
  end
  assign rf_do_a = (rf_sc >= 4'd1) ? core[rf_sc - 4'd1] : 8'h00;
  assign rf_do_b = (rf_sc >= 4'd2) ? core[rf_sc - 4'd2] : 8'h00;

  // Reference model: the stack as a queue, bottom at index 0.
  logic [7:0] mst [$];
  bit swap_pend, m_ovf, m_unf, exp_rv, exp_re;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare visible state; during SWAP2 the stack is one short with the old top on top.
  task automatic check_state();
    int n;
    int esc;
    n   = mst.size();
    esc = swap_pend ? n - 1 : n;
    chk("req_ready", req_ready, !swap_pend);
    chk("rf_sc", rf_sc, esc);
    chk("top_valid", top_valid, esc != 0);
    if (esc > 0) chk("top", top, swap_pend ? mst[n-2] : mst[n-1]);
    if (!swap_pend && n >= 2) chk("next", rf_do_b, mst[n-2]);
    chk("resp_valid", resp_valid, exp_rv);
    if (exp_rv) chk("resp_err", resp_err, exp_re);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_unf", err_unf, m_unf);
  endtask

  // One cycle: drive at the falling edge, check the write strobe, advance the model.
  task automatic step(input bit v, input logic [2:0] c, input logic [7:0] imm, input bit clr);
    int n;
    bit legal, ovf_n, unf_n, wr;
    logic [7:0] a, b, r;
    req_valid = v;
    req_cmd   = c;
    req_imm   = imm;
    clr_err   = clr;
    #1;
    n = mst.size();
    legal = 1'b1;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    case (c)
      CmdPush:                         legal = (n < 13);
      CmdPop:                          legal = (n >= 1);
      CmdDup:                          legal = (n >= 1) && (n < 13);
      CmdAdd, CmdSub, CmdAnd, CmdSwap: legal = (n >= 2);
      default:                         legal = 1'b1;
    endcase
    if (!legal) begin
      if ((c == CmdPush || c == CmdDup) && n >= 13) ovf_n = 1'b1;
      else                                          unf_n = 1'b1;
    end
    if (swap_pend) begin
      ovf_n = 1'b0;
      unf_n = 1'b0;
      wr    = 1'b1;
    end else begin
      wr = v && legal && (c != CmdNop) && (c != CmdPop);
      if (!v) begin
        ovf_n = 1'b0;
        unf_n = 1'b0;
      end
    end
    chk("rf_we", rf_we, wr);

    if (swap_pend) begin
      swap_pend = 1'b0;
      exp_rv    = 1'b1;
      exp_re    = 1'b0;
    end else if (v) begin
      exp_rv = 1'b1;
      exp_re = !legal;
      if (legal) begin
        case (c)
          CmdPush: mst.push_back(imm);
          CmdPop:  r = mst.pop_back();
          CmdDup:  mst.push_back(mst[n-1]);
          CmdAdd, CmdSub, CmdAnd: begin
            a = mst.pop_back();
            b = mst.pop_back();
            if (c == CmdAdd)      r = b + a;
            else if (c == CmdSub) r = b - a;
            else                  r = b & a;
            mst.push_back(r);
          end
          CmdSwap: begin
            a = mst.pop_back();
            b = mst.pop_back();
            mst.push_back(a);
            mst.push_back(b);
            swap_pend = 1'b1;
            exp_rv    = 1'b0;
          end
          default: ;
        endcase
      end
    end else begin
      exp_rv = 1'b0;
      exp_re = 1'b0;
    end
    m_ovf = ovf_n | (m_ovf & !clr);
    m_unf = unf_n | (m_unf & !clr);
    @(negedge clk);
    check_state();
  endtask

  // Pulse reset across one rising edge; write strobe and ready must drop at once.
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    clr_err   = 1'b0;
    #1;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_sc", rf_sc, 4'd0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mst.delete();
    swap_pend = 1'b0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    exp_rv    = 1'b0;
    exp_re    = 1'b0;
    #1;
    check_state();
    @(negedge clk);
  endtask

  initial begin
    int r;
    bit v;
    logic [2:0] c;
    for (int i = 0; i < 16; i++) core[i] = 8'h00;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_cmd   = CmdNop;
    req_imm   = 8'h00;
    clr_err   = 1'b0;
    @(negedge clk);
    chk("reset_top_valid", top_valid, 1'b0);
    chk("reset_err_ovf", err_ovf, 1'b0);
    do_reset();

    // PUSH 5, PUSH 3, then SUB; then 3,5 SUB wraps.
    step(1, CmdPush, 8'd5, 0);
    chk("tp1_resp", {resp_valid, resp_err}, 2'b10);
    step(1, CmdPush, 8'd3, 0);
    chk("tp1_sc", rf_sc, 4'd2);
    chk("tp1_top", top, 8'd3);
    step(1, CmdSub, 8'h00, 0);
    chk("tp2_top", top, 8'd2);
    chk("tp2_sc", rf_sc, 4'd1);
    step(1, CmdPop, 8'h00, 0);
    step(1, CmdPush, 8'd3, 0);
    step(1, CmdPush, 8'd5, 0);
    step(1, CmdSub, 8'h00, 0);
    chk("tp2_wrap", top, 8'hFE);
    step(1, CmdPop, 8'h00, 0);

    // SWAP with a request held during SWAP2 (must be ignored).
    step(1, CmdPush, 8'hAA, 0);
    step(1, CmdPush, 8'h55, 0);
    step(1, CmdSwap, 8'h00, 0);
    chk("tp3_ready_low", req_ready, 1'b0);
    chk("tp3_no_resp_yet", resp_valid, 1'b0);
    step(1, CmdPush, 8'h99, 0);
    chk("tp3_resp", resp_valid, 1'b1);
    chk("tp3_top", top, 8'hAA);
    chk("tp3_next", rf_do_b, 8'h55);
    chk("tp3_sc", rf_sc, 4'd2);

    // Fill, overflow, clear.
    do_reset();
    for (int i = 0; i < 13; i++) step(1, CmdPush, 8'(i + 1), 0);
    step(1, CmdPush, 8'hEE, 0);
    chk("tp4_sc", rf_sc, 4'd13);
    chk("tp4_err", {resp_err, err_ovf}, 2'b11);
    chk("tp4_top", top, 8'd13);
    step(1, CmdDup, 8'h00, 0);
    step(0, CmdNop, 8'h00, 1);
    chk("tp4_clr", err_ovf, 1'b0);
    // Clear loses to a same-edge error.
    step(1, CmdPush, 8'h01, 1);
    chk("tp4_clr_loses", err_ovf, 1'b1);

    // Underflows from empty and from one entry.
    do_reset();
    step(1, CmdPop, 8'h00, 0);
    chk("tp5_pop", {resp_err, err_unf, rf_sc}, {2'b11, 4'd0});
    step(1, CmdPush, 8'd7, 0);
    step(1, CmdAdd, 8'h00, 0);
    chk("tp5_add", {resp_err, err_unf, rf_sc}, {2'b11, 4'd1});
    step(1, CmdSwap, 8'h00, 0);
    chk("tp5_swap1", {resp_valid, resp_err, req_ready}, 3'b111);

    // Reset during SWAP2.
    step(1, CmdPush, 8'h42, 0);
    step(1, CmdSwap, 8'h00, 0);
    chk("tp6_in_swap2", req_ready, 1'b0);
    do_reset();
    chk("tp6_sc", rf_sc, 4'd0);
    chk("tp6_top_valid", top_valid, 1'b0);

    // Randomized traffic, biased toward growing the stack.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 3)       c = CmdPush;
      else if (r == 3) c = CmdDup;
      else if (r == 4) c = CmdPop;
      else             c = 3'($urandom_range(0, 7));
      step(v, c, 8'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
